// File: rtl/bs_drvr_intf.sv
// bs_drvr_intf: per-driver bus interface with a TX FIFO toward the bus and a
// destination-filtered RX FIFO toward the host.
// Optional statistics counters are enabled by defining BS_DRVR_STATS_EN.

// Circular-buffer FIFO with first-word-fall-through head and overflow pulse.
module bs_drvr_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr,
    input  logic [W-1:0]               din,
    input  logic                       rd,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_rd;
    logic          do_wr;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    always_comb begin
        do_rd = rd && (cnt != '0);
        do_wr = wr && ((cnt < FULL_CNT) || ((cnt == FULL_CNT) && rd));
    end

    // Pointers, occupancy and the registered overflow pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            ovf <= wr && !do_wr;
        end
    end

    // Storage is not reset; an empty FIFO masks its head to zero instead.
    always_ff @(posedge clk) begin
        if (!reset && do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Head entry is visible whenever the FIFO holds anything.
    always_comb begin
        dout = '0;
        if (cnt != '0) begin
            dout = mem[rd_ptr];
        end
    end
endmodule

module bs_drvr_intf #(
    parameter int         PCKG_SZ   = 32,
    parameter int         DEPTH     = 8,
    parameter logic [7:0] DRVR_ID   = 8'd0,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_tx,
    input  logic [PCKG_SZ-1:0]         D_tx,
    output logic                       tx_full,
    output logic [$clog2(DEPTH):0]     tx_cnt,
    output logic                       tx_ovf,
    output logic                       pndng,
    output logic [PCKG_SZ-1:0]         D_pop,
    input  logic                       pop,
    input  logic                       push,
    input  logic [PCKG_SZ-1:0]         D_push,
    output logic                       rx_vld,
    output logic [PCKG_SZ-1:0]         D_rx,
    input  logic                       rd_rx,
    output logic [$clog2(DEPTH):0]     rx_cnt,
    output logic                       rx_ovf,
    output logic                       rx_misrt
`ifdef BS_DRVR_STATS_EN
    ,
    output logic [15:0]                tx_ovf_cnt,
    output logic [15:0]                rx_ovf_cnt,
    output logic [15:0]                rx_misrt_cnt
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [7:0] target;
    logic       addr_match;

    bs_drvr_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_tx),
        .din   (D_tx),
        .rd    (pop),
        .dout  (D_pop),
        .cnt   (tx_cnt),
        .ovf   (tx_ovf)
    );

    bs_drvr_fifo #(.W(PCKG_SZ), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (push && addr_match),
        .din   (D_push),
        .rd    (rd_rx),
        .dout  (D_rx),
        .cnt   (rx_cnt),
        .ovf   (rx_ovf)
    );

    // Status flags and the destination filter for bus deliveries.
    always_comb begin
        target     = D_push[PCKG_SZ-1:PCKG_SZ-8];
        addr_match = (target == DRVR_ID) || (target == BROADCAST);
        pndng      = (tx_cnt != '0);
        tx_full    = (tx_cnt == FULL_CNT);
        rx_vld     = (rx_cnt != '0);
    end

    // Registered pulse for deliveries addressed to some other driver.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_misrt <= 1'b0;
        end else begin
            rx_misrt <= push && !addr_match;
        end
    end

`ifdef BS_DRVR_STATS_EN
    // Saturating event counters driven by the registered pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_ovf_cnt   <= '0;
            rx_ovf_cnt   <= '0;
            rx_misrt_cnt <= '0;
        end else begin
            if (tx_ovf && (tx_ovf_cnt != 16'hFFFF)) begin
                tx_ovf_cnt <= tx_ovf_cnt + 16'd1;
            end
            if (rx_ovf && (rx_ovf_cnt != 16'hFFFF)) begin
                rx_ovf_cnt <= rx_ovf_cnt + 16'd1;
            end
            if (rx_misrt && (rx_misrt_cnt != 16'hFFFF)) begin
                rx_misrt_cnt <= rx_misrt_cnt + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_bs_drvr_intf.sv
// Testbench for bs_drvr_intf (DEPTH=4, DRVR_ID=1): directed scenarios followed
// by random traffic, checked against a queue-based reference model.
module tb_bs_drvr_intf;
    localparam int PCKG_SZ = 32;
    localparam int DEPTH   = 4;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               wr_tx = 1'b0;
    logic [PCKG_SZ-1:0] D_tx = '0;
    logic               tx_full;
    logic [CW-1:0]      tx_cnt;
    logic               tx_ovf;
    logic               pndng;
    logic [PCKG_SZ-1:0] D_pop;
    logic               pop = 1'b0;
    logic               push = 1'b0;
    logic [PCKG_SZ-1:0] D_push = '0;
    logic               rx_vld;
    logic [PCKG_SZ-1:0] D_rx;
    logic               rd_rx = 1'b0;
    logic [CW-1:0]      rx_cnt;
    logic               rx_ovf;
    logic               rx_misrt;

    bs_drvr_intf #(.PCKG_SZ(PCKG_SZ), .DEPTH(DEPTH), .DRVR_ID(8'h01), .BROADCAST(8'hFF)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_tx    (wr_tx),
        .D_tx     (D_tx),
        .tx_full  (tx_full),
        .tx_cnt   (tx_cnt),
        .tx_ovf   (tx_ovf),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .rx_vld   (rx_vld),
        .D_rx     (D_rx),
        .rd_rx    (rd_rx),
        .rx_cnt   (rx_cnt),
        .rx_ovf   (rx_ovf),
        .rx_misrt (rx_misrt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tx_cnt;
        logic        tx_ovf;
        logic [31:0] d_pop;
        int          rx_cnt;
        logic        rx_ovf;
        logic        rx_misrt;
        logic [31:0] d_rx;
    } snap_t;

    snap_t       exp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the reference model and queues the
    // state expected right after the coming clock edge.
    task automatic applyStimulus(input logic rst, input logic wr, input logic [31:0] dtx,
                                 input logic pp, input logic ps, input logic [31:0] dps,
                                 input logic rd);
        snap_t s;
        logic  t_acc, r_match, r_acc;
        reset = rst; wr_tx = wr; D_tx = dtx; pop = pp;
        push = ps; D_push = dps; rd_rx = rd;
        s.tx_ovf = 1'b0; s.rx_ovf = 1'b0; s.rx_misrt = 1'b0;
        if (rst) begin
            tx_q.delete();
            rx_q.delete();
        end else begin
            t_acc = wr && (tx_q.size() < DEPTH || (tx_q.size() == DEPTH && pp));
            s.tx_ovf = wr && !t_acc;
            if (pp && tx_q.size() > 0) void'(tx_q.pop_front());
            if (t_acc) tx_q.push_back(dtx);
            r_match = (dps[31:24] == 8'h01) || (dps[31:24] == 8'hFF);
            r_acc = ps && r_match && (rx_q.size() < DEPTH || (rx_q.size() == DEPTH && rd));
            s.rx_misrt = ps && !r_match;
            s.rx_ovf = ps && r_match && !r_acc;
            if (rd && rx_q.size() > 0) void'(rx_q.pop_front());
            if (r_acc) rx_q.push_back(dps);
        end
        s.tx_cnt = tx_q.size();
        s.rx_cnt = rx_q.size();
        s.d_pop = (tx_q.size() > 0) ? tx_q[0] : 32'h0;
        s.d_rx = (rx_q.size() > 0) ? rx_q[0] : 32'h0;
        exp_q.push_back(s);
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every clock edge compare the DUT against the queued expectation.
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() == 0) begin
                checkOutput("expectation_available", 32'd0, 32'd1);
            end else begin
                s = exp_q.pop_front();
                checkOutput("tx_cnt", 32'(tx_cnt), 32'(s.tx_cnt));
                checkOutput("tx_full", 32'(tx_full), 32'(s.tx_cnt == DEPTH));
                checkOutput("pndng", 32'(pndng), 32'(s.tx_cnt > 0));
                checkOutput("tx_ovf", 32'(tx_ovf), 32'(s.tx_ovf));
                checkOutput("D_pop", D_pop, s.d_pop);
                checkOutput("rx_cnt", 32'(rx_cnt), 32'(s.rx_cnt));
                checkOutput("rx_vld", 32'(rx_vld), 32'(s.rx_cnt > 0));
                checkOutput("rx_ovf", 32'(rx_ovf), 32'(s.rx_ovf));
                checkOutput("rx_misrt", 32'(rx_misrt), 32'(s.rx_misrt));
                checkOutput("D_rx", D_rx, s.d_rx);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then randomized traffic with occasional resets.
    initial begin
        logic [7:0]  tgt;
        logic [31:0] pk;
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'h01000005, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 1, 32'h01000000 + k, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(0, 1, 32'h02000000 + k, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h000000AA, 1, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h01000007, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'hFF020008, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h02000009, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 1, 32'h01000100 + k, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'hFF000200, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h01000201, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 32'h01000300 + k, 0, 1, 32'h01000400 + k, 0);
        applyStimulus(1, 1, 32'h01000999, 1, 1, 32'h01000999, 1);
        applyStimulus(0, 1, 32'h01000010, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 3))
                0: tgt = 8'h01;
                1: tgt = 8'hFF;
                2: tgt = 8'h02;
                default: tgt = 8'($urandom);
            endcase
            pk = {tgt, 24'($urandom)};
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, $urandom,
                          $urandom_range(0, 9) < 5, $urandom_range(0, 9) < 6, pk,
                          $urandom_range(0, 9) < 4);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("leftover_expectations", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
